// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-forward select codes and the per-stage
// destination tracker record used by the hazard controller.
package pipe_pkg;

  localparam int RW = 5;

  localparam logic [1:0] FWD_QR  = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_MR  = 2'b10;
  localparam logic [1:0] FWD_MDO = 2'b11;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic [RW-1:0] rn;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel_logic.sv
// Combinational forward select for one ID operand, zero latency.
// Also flags a load in EXE that this operand depends on (load-use hazard).
module fwd_sel_logic
  import pipe_pkg::*;
#(
  parameter int RW = pipe_pkg::RW
) (
  input  logic          valid,
  input  logic          rd_en,
  input  logic [RW-1:0] src,
  input  logic          e_wreg,
  input  logic          e_m2reg,
  input  logic [RW-1:0] e_rn,
  input  logic          m_wreg,
  input  logic          m_m2reg,
  input  logic [RW-1:0] m_rn,
  output logic [1:0]    sel,
  output logic          load_hazard
);

  logic live;
  logic hit_e;
  logic hit_m;

  // r0 is hard-wired zero, so it never matches a producer.
  assign live  = valid && rd_en;
  assign hit_e = e_wreg && (e_rn == src) && (src != '0);
  assign hit_m = m_wreg && (m_rn == src) && (src != '0);

  assign load_hazard = live && hit_e && e_m2reg;

  // EXE is checked first: it holds the younger producer.
  always_comb begin
    sel = FWD_QR;
    if (live) begin
      if (hit_e && !e_m2reg) begin
        sel = FWD_ALU;
      end else if (hit_m && !m_m2reg) begin
        sel = FWD_MR;
      end else if (hit_m && m_m2reg) begin
        sel = FWD_MDO;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: combinational selects and stall, trackers update
// on the clock edge; a load-use hazard holds IF/ID one cycle and bubbles ID/EXE.
module fwd_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RW = pipe_pkg::RW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic [RW-1:0] id_rn,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  stage_t e_q;
  stage_t m_q;
  stage_t e_next;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       haz_a;
  logic       haz_b;

  fwd_sel_logic #(.RW(RW)) u_sel_a (
    .valid       (id_valid),
    .rd_en       (id_use_rs),
    .src         (id_rs),
    .e_wreg      (e_q.wreg),
    .e_m2reg     (e_q.m2reg),
    .e_rn        (e_q.rn),
    .m_wreg      (m_q.wreg),
    .m_m2reg     (m_q.m2reg),
    .m_rn        (m_q.rn),
    .sel         (sel_a),
    .load_hazard (haz_a)
  );

  fwd_sel_logic #(.RW(RW)) u_sel_b (
    .valid       (id_valid),
    .rd_en       (id_use_rt),
    .src         (id_rt),
    .e_wreg      (e_q.wreg),
    .e_m2reg     (e_q.m2reg),
    .e_rn        (e_q.rn),
    .m_wreg      (m_q.wreg),
    .m_m2reg     (m_q.m2reg),
    .m_rn        (m_q.rn),
    .sel         (sel_b),
    .load_hazard (haz_b)
  );

  assign stall = haz_a || haz_b;

  // The stalled instruction re-presents next cycle, so its selects are don't-care now.
  assign fwda = stall ? FWD_QR : sel_a;
  assign fwdb = stall ? FWD_QR : sel_b;

  always_comb begin
    e_next = STAGE_BUBBLE;
    if (id_valid && !stall) begin
      e_next.wreg  = id_wreg;
      e_next.m2reg = id_m2reg;
      e_next.rn    = id_rn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= STAGE_BUBBLE;
      m_q <= STAGE_BUBBLE;
    end else begin
      m_q <= e_q;
      e_q <= e_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Forwarding and hazard controller for the 5-stage pipeline. It generates the 2-bit select codes for the forward-A and forward-B operand muxes, which sit in the ID stage ahead of the ID/EXE register. It tracks the destination register of the instructions in EXE and MEM, detects load-use hazards and stalls IF/ID for one cycle while injecting a bubble. It also keeps a saturating stall counter for performance debug.

Parameters:
RW, 5, register-number width (32 GPRs; r0 hard-wired zero)
CW, 16, stall-counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction (0 = bubble or flushed)
id_rs  in  RW  source register A of the ID instruction
id_rt  in  RW  source register B of the ID instruction
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_wreg  in  1  ID instruction writes the register file
id_m2reg  in  1  ID instruction is a load (result comes from data memory)
id_rn  in  RW  destination register of the ID instruction
fwda  out  2  select for the qa operand mux
fwdb  out  2  select for the qb operand mux
stall  out  1  1 = hold PC and IF/ID, inject bubble into ID/EXE
stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
- Select encoding, shared by fwda and fwdb: 00 = register-file read (qa/qb); 01 = EXE ALU result r; 10 = EXE/MEM latched result mr; 11 = data-memory output mdo.
- Internal tracker E = {e_wreg, e_m2reg, e_rn} mirrors ID/EXE. Tracker M = {m_wreg, m_m2reg, m_rn} mirrors EXE/MEM.
- Reset (async, immediate): E, M and stall_cnt = 0, so fwda = fwdb = 00 and stall = 0.
- Match helpers:
  - hitE(x) = e_wreg & (e_rn == x) & (x != 0)
  - hitM(x) = m_wreg & (m_rn == x) & (x != 0)
- Operand-A select, combinational, same cycle:
  - if !id_valid or !id_use_rs: 00
  - else if hitE(rs) & !e_m2reg: 01
  - else if hitM(rs) & !m_m2reg: 10
  - else if hitM(rs) & m_m2reg: 11
  - else: 00
  - EXE has priority over MEM (it is the younger producer).
- Operand-B select: same rules using rt and id_use_rt.
- Load-use hazard, combinational:
  - stall = id_valid & e_m2reg & ((id_use_rs & hitE(rs)) | (id_use_rt & hitE(rt)))
  - While stall = 1, fwda and fwdb are forced to 00.
- Clock edge:
  - M <= E, always.
  - If stall or !id_valid: E <= {0, 0, 0} (bubble).
  - Else: E <= {id_wreg, id_m2reg, id_rn}.
- Stall duration: exactly one cycle per load-use hazard. On the next cycle the load is in MEM, so the same ID instruction now resolves to select 11.
- stall_cnt: increments on each clock edge where stall = 1 and holds at all-ones (no wrap).
- Boundary cases:
  - r0 never forwards and never stalls.
  - If rs == rt and both match, fwda and fwdb both select the same source.
  - A load in EXE with a non-load writer to the same register in MEM: stall (EXE hit wins).
  - id_wreg = 0 with m2reg = 1 (store-like): no forwarding and no stall, because wreg gates matching.
  - Reset asserted mid-stall: stall drops immediately, trackers clear, counter clears.

Decomposition:
- Shared package pipe_pkg:
  - localparams FWD_QR = 2'b00, FWD_ALU = 2'b01, FWD_MR = 2'b10, FWD_MDO = 2'b11
  - RW
  - a struct or bundle {wreg, m2reg, rn} for stage tracking
- One natural sub-module: fwd_sel_logic, the combinational select for a single operand. Instantiate it twice (rs and rt), each taking the E/M tracker fields.
- Tracker flops and stall_cnt live in the top module.

Test Plan:
1. Reset pulse mid-run with E/M holding valid writers -> within the same cycle fwda = fwdb = 00, stall = 0, stall_cnt = 0.
2. Instruction writing r5 (non-load) followed by a reader of rs = 5 -> fwda = 01. Then with a NOP between -> fwda = 10. With two NOPs -> fwda = 00.
3. Load to r7 followed immediately by a reader with rt = 7 -> stall = 1 for exactly one cycle with fwdb = 00. Next cycle stall = 0 and fwdb = 11. stall_cnt increments by 1.
4. Writer r3 in MEM (non-load) and writer r3 in EXE (non-load), ID reads rs = rt = 3 -> fwda = fwdb = 01 (EXE priority).
5. Writer to r0 followed by a reader of rs = 0, and a load to r0 followed by a reader of rt = 0 -> selects 00, no stall.
6. With CW = 4, force 20 back-to-back load-use pairs -> stall_cnt saturates at 15 and holds. id_valid = 0 during a would-be hazard -> stall = 0.
